// File: rtl/command_encoder_if.sv
// rtl/command_encoder_if.sv - request handshake and command byte bus between host and command_encoder.
interface command_encoder_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [2:0] req_a;
  logic [2:0] req_b;
  logic [2:0] req_c;
  logic [2:0] req_d;
  logic [7:0] cmd_byte;
  logic       busy;
  logic       done;

  modport master (
    output req_valid, req_op, req_a, req_b, req_c, req_d,
    input  req_ready, cmd_byte, busy, done
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_c, req_d,
    output req_ready, cmd_byte, busy, done
  );
endinterface

// File: rtl/command_encoder.sv
// rtl/command_encoder.sv - serialises one drawing request into the rasterizer command byte stream.
module command_encoder #(
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  command_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_PARAM,
    S_GAP
  } state_t;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_PIXEL = 2'b01;

  // Out-of-range gap settings are pinned to 1..15 so the 4-bit counter can never wrap.
  localparam int unsigned GAP_EFF  = (GAP_CYCLES < 1) ? 1 : ((GAP_CYCLES > 15) ? 15 : GAP_CYCLES);
  localparam logic [3:0]  GAP_LAST = 4'(GAP_EFF - 1);

  state_t     state_q, state_d;
  logic [1:0] op_q;
  logic [2:0] b_q, c_q, d_q;
  logic [1:0] idx_q, idx_d;
  logic [3:0] gap_q, gap_d;
  logic [7:0] byte_q, byte_d;

  logic       accept;
  logic [1:0] idx_last;
  logic [2:0] opnd_next;
  logic [7:0] header_byte;

  assign accept    = bus.req_valid && (state_q == S_IDLE);
  assign idx_last  = (op_q == OP_PIXEL) ? 2'd0 : 2'd2;
  assign opnd_next = (idx_q == 2'd0) ? c_q : d_q;

  // The opcode doubles as the cmd field; CLEAR is the one opcode with a fixed byte.
  assign header_byte = (bus.req_op == OP_CLEAR) ? 8'hBF
                                                : {1'b1, bus.req_op, 2'b00, bus.req_a};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_HEADER;
      S_HEADER: state_d = (op_q == OP_CLEAR) ? S_GAP : S_PARAM;
      S_PARAM:  if (idx_q == idx_last) state_d = S_GAP;
      S_GAP:    if (gap_q == GAP_LAST) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // byte_d is the byte that belongs to state_d, so cmd_byte stays aligned with the state register.
  always_comb begin
    byte_d = 8'h00;
    idx_d  = idx_q;
    gap_d  = gap_q;
    case (state_q)
      S_IDLE: begin
        idx_d = 2'd0;
        gap_d = 4'd0;
        if (accept) byte_d = header_byte;
      end
      S_HEADER: begin
        idx_d = 2'd0;
        if (op_q != OP_CLEAR) byte_d = {3'b100, 2'b00, b_q};
      end
      S_PARAM: begin
        if (idx_q != idx_last) begin
          idx_d  = 2'(idx_q + 2'd1);
          byte_d = {3'b100, 2'b00, opnd_next};
        end
      end
      S_GAP: begin
        gap_d = (gap_q == GAP_LAST) ? 4'd0 : 4'(gap_q + 4'd1);
      end
      default: begin
        idx_d = 2'd0;
        gap_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_q <= 8'h00;
      idx_q  <= 2'd0;
      gap_q  <= 4'd0;
      op_q   <= 2'd0;
      b_q    <= 3'd0;
      c_q    <= 3'd0;
      d_q    <= 3'd0;
    end else begin
      byte_q <= byte_d;
      idx_q  <= idx_d;
      gap_q  <= gap_d;
      if (accept) begin
        op_q <= bus.req_op;
        b_q  <= bus.req_b;
        c_q  <= bus.req_c;
        d_q  <= bus.req_d;
      end
    end
  end

  assign bus.cmd_byte  = byte_q;
  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_GAP) && (gap_q == GAP_LAST);

endmodule
